// File: rtl/instruction_fetch.sv
// instruction_fetch
// -----------------------------------------------------------------------------
// Fetch stage ahead of instruction_decoder. Owns the 8-bit program counter,
// fetches one 16-bit word at a time from program ROM over a req/valid
// handshake, presents it to the decoder for exactly one EXEC cycle and applies
// the decoder's redirect at the end of that cycle. A response watchdog moves
// the block into a sticky FAULT state if the ROM never answers.
//
// Parameters:
//   RESET_PC           PC loaded on reset
//   TIMEOUT_CYCLES     max cycles spent in WAIT before FAULT (1..255)
//
// Ports:
//   clk                system clock
//   sync_rst           synchronous active-high reset (priority over clk_en)
//   clk_en             global stall; low holds all state and gates rom_req
//   halt               in FETCH, suppresses the request
//   rom_addr    [7:0]  fetch address (copy of the PC register)
//   rom_req            one-cycle fetch request (combinational from state)
//   rom_data   [15:0]  ROM read data, qualified by rom_valid
//   rom_valid          one-cycle ROM response strobe
//   instruction[15:0]  registered instruction for the decoder
//   instruction_valid  high exactly while in EXEC
//   pc_out      [7:0]  address of the current instruction
//   pc_overwrite_data  redirect target from the decoder
//   pc_overwrite_en    redirect request from the decoder (EXEC only)
//   fault              sticky ROM-timeout flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [7:0]  RESET_PC       = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        clk_en,
  input  logic        halt,
  output logic [7:0]  rom_addr,
  output logic        rom_req,
  input  logic [15:0] rom_data,
  input  logic        rom_valid,
  output logic [15:0] instruction,
  output logic        instruction_valid,
  output logic [7:0]  pc_out,
  input  logic [7:0]  pc_overwrite_data,
  input  logic        pc_overwrite_en,
  output logic        fault
);

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 8;

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_next;
  logic [INSTR_W-1:0] instr_next;
  logic               req_c;

  // Next-state, datapath and request decode
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    wait_cnt_next = wait_cnt;
    instr_next    = instruction;
    req_c         = 1'b0;

    unique case (state)
      ST_FETCH: begin
        if (!halt) begin
          req_c         = 1'b1;
          state_next    = ST_WAIT;
          wait_cnt_next = '0;
        end
      end

      ST_WAIT: begin
        // A response on the last allowed cycle still beats the watchdog.
        if (rom_valid) begin
          instr_next = rom_data;
          state_next = ST_EXEC;
        end else begin
          wait_cnt_next = CNT_W'(wait_cnt + CNT_W'(1));
          if (wait_cnt_next == TIMEOUT_LIMIT) begin
            state_next = ST_FAULT;
          end
        end
      end

      ST_EXEC: begin
        // Plain increment wraps FF -> 00 through the 8-bit width.
        if (pc_overwrite_en) begin
          pc_next = pc_overwrite_data;
        end else begin
          pc_next = PC_W'(pc + PC_W'(1));
        end
        state_next = ST_FETCH;
      end

      ST_FAULT: begin
        state_next = ST_FAULT;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers; reset wins over the clock enable
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state             <= ST_FETCH;
      pc                <= RESET_PC;
      wait_cnt          <= '0;
      instruction       <= '0;
      instruction_valid <= 1'b0;
      fault             <= 1'b0;
    end else if (clk_en) begin
      state             <= state_next;
      pc                <= pc_next;
      wait_cnt          <= wait_cnt_next;
      instruction       <= instr_next;
      instruction_valid <= (state_next == ST_EXEC);
      fault             <= (state_next == ST_FAULT);
    end
  end

  // Request is suppressed while stalled and during the reset cycle itself
  assign rom_req  = req_c & clk_en & ~sync_rst;
  assign rom_addr = pc;
  assign pc_out   = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// -----------------------------------------------------------------------------
// Directed bench for instruction_fetch (RESET_PC=00, TIMEOUT_CYCLES=4).
// A small ROM model answers each request with word A000+addr after a
// programmable number of cycles, or stays silent when disabled.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units
// later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        clk_en;
  logic        halt;
  logic [7:0]  rom_addr;
  logic        rom_req;
  logic [15:0] rom_data;
  logic        rom_valid;
  logic [15:0] instruction;
  logic        instruction_valid;
  logic [7:0]  pc_out;
  logic [7:0]  pc_overwrite_data;
  logic        pc_overwrite_en;
  logic        fault;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC      (8'h00),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .sync_rst         (sync_rst),
    .clk_en           (clk_en),
    .halt             (halt),
    .rom_addr         (rom_addr),
    .rom_req          (rom_req),
    .rom_data         (rom_data),
    .rom_valid        (rom_valid),
    .instruction      (instruction),
    .instruction_valid(instruction_valid),
    .pc_out           (pc_out),
    .pc_overwrite_data(pc_overwrite_data),
    .pc_overwrite_en  (pc_overwrite_en),
    .fault            (fault)
  );

  int checks = 0;
  int errors = 0;

  // ROM model state
  bit         rom_on    = 1'b1;
  int         rom_delay = 1;
  bit         pend      = 1'b0;
  int         cd        = 0;
  logic [7:0] req_addr  = 8'h00;
  bit         req_prev  = 1'b0;
  logic [7:0] addr_prev = 8'h00;
  bit         rst_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and drive the ROM response for the new cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
    rom_valid = 1'b0;
    if (rst_prev) pend = 1'b0;
    if (req_prev && rom_on) begin
      pend     = 1'b1;
      cd       = rom_delay;
      req_addr = addr_prev;
    end
    if (pend) begin
      cd--;
      if (cd == 0) begin
        rom_valid = 1'b1;
        rom_data  = 16'hA000 + {8'h00, req_addr};
        pend      = 1'b0;
      end
    end
  endtask

  // Let outputs settle and record what the ROM sees this cycle
  task automatic settle();
    #3;
    req_prev  = rom_req;
    addr_prev = rom_addr;
    rst_prev  = sync_rst;
  endtask

  task automatic step();
    next_cycle();
    settle();
  endtask

  initial begin
    bit found;
    sync_rst          = 1'b1;
    clk_en            = 1'b1;
    halt              = 1'b0;
    rom_data          = 16'h0000;
    rom_valid         = 1'b0;
    pc_overwrite_data = 8'h00;
    pc_overwrite_en   = 1'b0;

    // Reset cycle and reset values
    settle();
    check("reset_cycle_req", 32'(rom_req), 0);
    next_cycle();
    sync_rst = 1'b0;
    settle();
    check("reset_pc", 32'(pc_out), 'h00);
    check("reset_instr", 32'(instruction), 'h0000);
    check("reset_ivalid", 32'(instruction_valid), 0);
    check("reset_fault", 32'(fault), 0);

    // Sequential fetch: F,W,E cadence for addresses 00..02
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      case (k % 3)
        0: begin
          check("seq_req", 32'(rom_req), 1);
          check("seq_addr", 32'(rom_addr), k / 3);
          check("seq_ivalid_f", 32'(instruction_valid), 0);
        end
        1: begin
          check("seq_req_w", 32'(rom_req), 0);
          check("seq_ivalid_w", 32'(instruction_valid), 0);
        end
        default: begin
          check("seq_ivalid_e", 32'(instruction_valid), 1);
          check("seq_instr", 32'(instruction), 'hA000 + k / 3);
          check("seq_pc", 32'(pc_out), k / 3);
        end
      endcase
    end

    // Redirect during EXEC of address 05
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instruction_valid && pc_out == 8'h05) found = 1'b1;
    end
    check("exec05_reached", 32'(found), 1);
    check("exec05_instr", 32'(instruction), 'hA005);
    pc_overwrite_en   = 1'b1;
    pc_overwrite_data = 8'h40;
    next_cycle();
    pc_overwrite_data = 8'h77;   // redirect held in FETCH/WAIT must be ignored
    settle();
    check("redir_addr", 32'(rom_addr), 'h40);
    check("redir_pc", 32'(pc_out), 'h40);
    check("redir_req", 32'(rom_req), 1);
    step();
    check("redir_wait_ivalid", 32'(instruction_valid), 0);
    next_cycle();
    pc_overwrite_en = 1'b0;
    settle();
    check("redir_exec_ivalid", 32'(instruction_valid), 1);
    check("redir_exec_pc", 32'(pc_out), 'h40);
    check("redir_exec_instr", 32'(instruction), 'hA040);

    // Redirect to FF, then a 3-cycle ROM delay and PC wrap
    pc_overwrite_en   = 1'b1;
    pc_overwrite_data = 8'hFF;
    rom_delay         = 3;
    next_cycle();
    pc_overwrite_en = 1'b0;
    settle();
    check("wrap_fetch_addr", 32'(rom_addr), 'hFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wrap_wait_ivalid", 32'(instruction_valid), 0);
      check("wrap_wait_req", 32'(rom_req), 0);
    end
    rom_delay = 1;
    step();
    check("wrap_exec_ivalid", 32'(instruction_valid), 1);
    check("wrap_exec_instr", 32'(instruction), 'hA0FF);

    // Halt for 5 cycles in FETCH at the wrapped address
    next_cycle();
    halt = 1'b1;
    settle();
    check("halt_req", 32'(rom_req), 0);
    check("halt_addr", 32'(rom_addr), 'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_req_hold", 32'(rom_req), 0);
    end
    next_cycle();
    halt = 1'b0;
    settle();
    check("halt_release_req", 32'(rom_req), 1);
    check("halt_release_addr", 32'(rom_addr), 'h00);
    step();
    step();
    check("halt_exec_instr", 32'(instruction), 'hA000);
    check("halt_exec_ivalid", 32'(instruction_valid), 1);

    // clk_en dropped during EXEC of address 01
    step();
    check("ce_fetch_addr", 32'(rom_addr), 'h01);
    step();
    step();
    check("ce_exec_ivalid", 32'(instruction_valid), 1);
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("ce_hold_ivalid", 32'(instruction_valid), 1);
      check("ce_hold_pc", 32'(pc_out), 'h01);
    end
    next_cycle();
    clk_en = 1'b1;
    settle();
    check("ce_last_ivalid", 32'(instruction_valid), 1);
    next_cycle();
    clk_en = 1'b0;               // stall in FETCH gates the request
    settle();
    check("ce_fetch_gated_req", 32'(rom_req), 0);
    check("ce_fetch_gated_addr", 32'(rom_addr), 'h02);
    next_cycle();
    clk_en = 1'b1;
    rom_on = 1'b0;
    settle();
    check("ce_fetch_req", 32'(rom_req), 1);

    // Reset in the middle of WAIT
    step();
    check("rstw_wait_ivalid", 32'(instruction_valid), 0);
    next_cycle();
    sync_rst = 1'b1;
    settle();
    check("rstw_req_in_reset", 32'(rom_req), 0);
    next_cycle();
    sync_rst = 1'b0;
    settle();
    check("rstw_pc", 32'(pc_out), 'h00);
    check("rstw_req", 32'(rom_req), 1);
    check("rstw_instr", 32'(instruction), 'h0000);

    // Timeout: silent ROM, fault exactly 4 cycles after WAIT entry
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_fault_low", 32'(fault), 0);
    end
    step();
    check("to_fault_high", 32'(fault), 1);
    check("to_req", 32'(rom_req), 0);
    step();
    check("to_req_later", 32'(rom_req), 0);
    next_cycle();
    rom_valid = 1'b1;
    rom_data  = 16'h1234;
    settle();
    check("to_fault_sticky", 32'(fault), 1);
    step();
    check("to_valid_ignored", 32'(instruction), 'h0000);
    check("to_ivalid", 32'(instruction_valid), 0);
    check("to_pc_frozen", 32'(pc_out), 'h00);
    next_cycle();
    sync_rst = 1'b1;
    settle();
    next_cycle();
    sync_rst  = 1'b0;
    rom_on    = 1'b1;
    rom_delay = 4;
    settle();
    check("to_clear_fault", 32'(fault), 0);
    check("to_clear_pc", 32'(pc_out), 'h00);
    check("to_clear_req", 32'(rom_req), 1);

    // Response on the last allowed WAIT cycle beats the watchdog
    for (int i = 0; i < 4; i++) begin
      step();
      check("lim_wait_ivalid", 32'(instruction_valid), 0);
    end
    step();
    check("lim_exec_ivalid", 32'(instruction_valid), 1);
    check("lim_exec_instr", 32'(instruction), 'hA000);
    check("lim_no_fault", 32'(fault), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of `instruction_decoder`. It owns the 8-bit program counter and fetches one 16-bit instruction at a time from program ROM over a request/valid handshake. Each instruction is presented to the decoder for exactly one execute cycle, and the redirect the decoder issues (`pc_overwrite_*`) is applied at the end of that cycle. A response watchdog latches a sticky fault if the ROM never answers.

## Interface

Parameters:
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `TIMEOUT_CYCLES`, default 15: maximum cycles spent in WAIT before a fault; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `sync_rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  when low, all state holds and `rom_req` is forced low.
- `halt`  in  1  when high in FETCH, no request is issued and the block stays in FETCH.
- `rom_addr`  out  8  fetch address; always equal to `pc_out`.
- `rom_req`  out  1  one-cycle fetch request.
- `rom_data`  in  16  ROM read data; valid only with `rom_valid`.
- `rom_valid`  in  1  response strobe, one cycle.
- `instruction`  out  16  registered instruction to the decoder.
- `instruction_valid`  out  1  high only in EXEC; the top level gates all decoder write/enable outputs with it.
- `pc_out`  out  8  address of the current instruction.
- `pc_overwrite_data`  in  8  redirect target from the decoder.
- `pc_overwrite_en`  in  1  redirect request from the decoder.
- `fault`  out  1  sticky ROM-timeout flag.

## Operation

- States: FETCH, WAIT, EXEC, FAULT. All state updates require `clk_en`=1; `sync_rst` takes priority over `clk_en`.
- FETCH:
  - `rom_req` = `clk_en` & ~`halt`.
  - If a request is issued, go to WAIT and clear the wait counter. Otherwise stay in FETCH.
- WAIT:
  - On `rom_valid`: capture `rom_data` into `instruction` and go to EXEC.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT_CYCLES`, go to FAULT.
  - If `rom_valid` arrives in the same cycle the counter reaches the limit, `rom_valid` wins.
- EXEC:
  - `instruction_valid`=1.
  - PC update: if `pc_overwrite_en`, pc <= `pc_overwrite_data`; otherwise pc <= pc+1, modulo 256, so 8'hFF wraps to 8'h00.
  - Next state is always FETCH.
- FAULT:
  - `fault`=1, no requests, PC frozen.
  - The only exit is `sync_rst`.
- Ignored inputs:
  - `rom_valid` outside WAIT is ignored.
  - `pc_overwrite_en` outside EXEC is ignored.
  - `halt` outside FETCH is ignored.
- `instruction` holds its last captured value outside EXEC.
- Only one request is outstanding at any time.
- The ROM shares `sync_rst`, so any response outstanding at reset is dropped by the ROM.
- Redirect to the current PC (self-loop) is legal: the block refetches the same address.

## Timing

- Reset values:
  - pc = `RESET_PC`
  - state = FETCH
  - `instruction` = 16'h0000
  - `instruction_valid` = 0
  - `fault` = 0
  - wait counter = 0
  - `rom_req` = 0 during the reset cycle
- Request timing: `rom_req` is combinational from state, `clk_en` and `halt`. `rom_addr` is a direct copy of the PC register.
- Earliest response: the cycle after `rom_req`. `rom_valid` in the same cycle as `rom_req` is ignored.
- Cadence with a zero-wait ROM: FETCH, WAIT, EXEC, giving 3 cycles per instruction. Each cycle of ROM delay adds one WAIT cycle.
- Redirect: `pc_out` shows the new value in the cycle after EXEC. `rom_addr` carries it in the same FETCH cycle.
- JMPL: the decoder's `pc_out+1` uses the EXEC-cycle PC, which is the address of the JMPL instruction itself.
- Timeout: with no `rom_valid`, FAULT is entered exactly `TIMEOUT_CYCLES` cycles after entering WAIT, and `fault` rises in that same cycle.
- `clk_en` low for N cycles stretches any state by N cycles with no other effect.

## Test plan

- Sequential fetch:
  - Stimulus: reset with `RESET_PC`=8'h00; ROM returns word 16'hA000+addr one cycle after each request.
  - Response: addresses 00,01,02 requested on cycles 0,3,6; `instruction_valid` pulses on cycles 2,5,8 with 16'hA000, 16'hA001, 16'hA002.
- Redirect:
  - Stimulus: assert `pc_overwrite_en`=1 with data 8'h40 during the EXEC of address 05.
  - Response: the next `rom_addr` is 8'h40 and `pc_out` is 8'h40. A redirect asserted in a non-EXEC cycle has no effect.
- Wrap and delay:
  - Stimulus: PC 8'hFF; ROM delays its response 3 cycles.
  - Response: WAIT lasts 3 cycles, then EXEC, then the next fetch address is 8'h00.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=4; ROM never responds.
  - Response: `fault` rises exactly 4 cycles after WAIT entry; no further `rom_req`; a later `rom_valid` is ignored; `sync_rst` clears `fault` and returns pc to `RESET_PC`.
- Halt, clk_en and reset:
  - Stimulus 1: hold `halt` for 5 cycles in FETCH.
    - Response: no `rom_req`; the fetch resumes on release.
  - Stimulus 2: drop `clk_en` during EXEC.
    - Response: `instruction_valid` stays high and the PC holds until `clk_en` returns.
  - Stimulus 3: assert `sync_rst` mid-WAIT.
    - Response: state returns to FETCH and pc to `RESET_PC` next cycle.
